// File: rtl/mul_div.sv
// MIPS-style multiply/divide unit with private HI/LO registers.
// Each result is computed when the request is accepted and committed when the busy interval ends.
module mul_div #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        mult,
   input  logic        multu,
   input  logic        div,
   input  logic        divu,
   input  logic        mfhi,
   input  logic        mflo,
   input  logic        mthi,
   input  logic        mtlo,
   output logic        start,
   output logic        busy,
   output logic [31:0] multdivout
);

   localparam int unsigned MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   logic [31:0]        hi;
   logic [31:0]        lo;
   logic [31:0]        pend_hi;
   logic [31:0]        pend_lo;
   logic               pend_we;
   logic [CNT_W-1:0]   cnt;

   logic               is_mul;
   logic               sdiv;
   logic signed [63:0] sa;
   logic signed [63:0] sb;
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic [63:0]        prod;
   logic               a_neg;
   logic               b_neg;
   logic [31:0]        mag_a;
   logic [31:0]        mag_b;
   logic [31:0]        uq;
   logic [31:0]        ur;
   logic [31:0]        quot;
   logic [31:0]        rem;

   assign start  = (mult | multu | div | divu) & ~busy;
   assign is_mul = mult | multu;
   assign sdiv   = ~is_mul & div;

   // Product: mult wins over multu when both strobes are present.
   assign sa     = {{32{a[31]}}, a};
   assign sb     = {{32{b[31]}}, b};
   assign prod_s = sa * sb;
   assign prod_u = {32'h0, a} * {32'h0, b};
   assign prod   = mult ? prod_s : prod_u;

   // Signed divide on magnitudes avoids the 0x80000000 / -1 overflow case.
   assign a_neg = sdiv & a[31];
   assign b_neg = sdiv & b[31];
   assign mag_a = a_neg ? (~a + 32'd1) : a;
   assign mag_b = (b == 32'h0) ? 32'd1 : (b_neg ? (~b + 32'd1) : b);
   assign uq    = mag_a / mag_b;
   assign ur    = mag_a % mag_b;
   assign quot  = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
   assign rem   = a_neg ? (~ur + 32'd1) : ur;

   always_ff @(posedge clk) begin
      if (!reset) begin
         hi      <= 32'h0;
         lo      <= 32'h0;
         pend_hi <= 32'h0;
         pend_lo <= 32'h0;
         pend_we <= 1'b0;
         busy    <= 1'b0;
         cnt     <= '0;
      end else if (busy) begin
         cnt <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) begin
            busy <= 1'b0;
            if (pend_we) begin
               hi <= pend_hi;
               lo <= pend_lo;
            end
         end
      end else if (start) begin
         busy    <= 1'b1;
         cnt     <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
         pend_hi <= is_mul ? prod[63:32] : rem;
         pend_lo <= is_mul ? prod[31:0]  : quot;
         pend_we <= is_mul | (b != 32'h0);
      end else if (mthi) begin
         hi <= a;
      end else if (mtlo) begin
         lo <= a;
      end
   end

   assign multdivout = mfhi ? hi : (mflo ? lo : 32'h0);

endmodule

// File: tb/tb_mul_div.sv
// Directed and random checks of mul_div against a plain-arithmetic HI/LO model.
module tb_mul_div;

   logic        clk;
   logic        reset;
   logic [31:0] a;
   logic [31:0] b;
   logic        mult;
   logic        multu;
   logic        div;
   logic        divu;
   logic        mfhi;
   logic        mflo;
   logic        mthi;
   logic        mtlo;
   logic        start;
   logic        busy;
   logic [31:0] multdivout;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] hi_m;
   logic [31:0] lo_m;

   mul_div #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .a(a), .b(b),
      .mult(mult), .multu(multu), .div(div), .divu(divu),
      .mfhi(mfhi), .mflo(mflo), .mthi(mthi), .mtlo(mtlo),
      .start(start), .busy(busy), .multdivout(multdivout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference result {HI,LO}; kind 0=mult 1=multu 2=div 3=divu.
   function automatic logic [63:0] ref_hilo(input int kind, input logic [31:0] x,
                                            input logic [31:0] y, input logic [63:0] cur);
      longint      sq;
      longint      sr;
      logic [63:0] r;
      case (kind)
         0: r = 64'(longint'($signed(x)) * longint'($signed(y)));
         1: r = {32'h0, x} * {32'h0, y};
         2: begin
            if (y == 32'h0) r = cur;
            else begin
               sq = longint'($signed(x)) / longint'($signed(y));
               sr = longint'($signed(x)) % longint'($signed(y));
               r  = {sr[31:0], sq[31:0]};
            end
         end
         default: r = (y == 32'h0) ? cur : {x % y, x / y};
      endcase
      return r;
   endfunction

   task automatic check_regs(input string tag);
      mfhi = 1'b1; #1;
      chk({tag, "_hi"}, multdivout, hi_m);
      mflo = 1'b1; #1;
      chk({tag, "_both_hi"}, multdivout, hi_m);
      mfhi = 1'b0; #1;
      chk({tag, "_lo"}, multdivout, lo_m);
      mflo = 1'b0; #1;
      chk({tag, "_none"}, multdivout, 32'h0);
   endtask

   // req = {mult,multu,div,divu}; inject 1 = extra mult while busy, 2 = mthi while busy
   task automatic op(input string tag, input logic [3:0] req, input logic [31:0] x,
                     input logic [31:0] y, input int inject);
      int          kind;
      int          n;
      logic [63:0] nx;
      kind = req[3] ? 0 : (req[2] ? 1 : (req[1] ? 2 : 3));
      n    = (kind < 2) ? 5 : 10;
      nx   = ref_hilo(kind, x, y, {hi_m, lo_m});
      a = x; b = y;
      {mult, multu, div, divu} = req;
      #1;
      chk({tag, "_start"}, 32'(start), 32'd1);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
      {mult, multu, div, divu} = 4'b0;
      for (int i = 0; i < n; i++) begin
         chk({tag, "_busy"}, 32'(busy), 32'd1);
         if (i == 2 && inject == 1) begin
            a = $urandom; b = $urandom; mult = 1'b1; #1;
            chk({tag, "_start_while_busy"}, 32'(start), 32'd0);
         end
         if (i == 2 && inject == 2) begin
            a = $urandom; mthi = 1'b1; #1;
         end
         @(posedge clk); #1;
         mult = 1'b0; mthi = 1'b0;
      end
      chk({tag, "_done"}, 32'(busy), 32'd0);
      {hi_m, lo_m} = nx;
      check_regs(tag);
   endtask

   initial begin
      logic [3:0]  req;
      logic [31:0] x;
      logic [31:0] y;
      reset = 1'b0; a = '0; b = '0;
      mult = 0; multu = 0; div = 0; divu = 0;
      mfhi = 0; mflo = 0; mthi = 0; mtlo = 0;
      hi_m = '0; lo_m = '0;
      @(posedge clk); #1;
      reset = 1'b1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_start", 32'(start), 32'd0);
      check_regs("rst");

      op("mult_5x3", 4'b1000, 32'd5, 32'd3, 0);

      // Reset in the middle of an operation aborts it.
      a = 32'd7; b = 32'd9; mult = 1'b1;
      @(posedge clk); #1;
      mult = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      hi_m = '0; lo_m = '0;
      chk("midrst_busy", 32'(busy), 32'd0);
      check_regs("midrst");
      repeat (6) @(posedge clk);
      #1;
      chk("midrst_later_busy", 32'(busy), 32'd0);
      check_regs("midrst_later");

      op("div_5_3", 4'b0010, 32'd5, 32'd3, 0);
      op("div_m7_2", 4'b0010, 32'hFFFF_FFF9, 32'd2, 0);
      chk("div_m7_2_lo_const", lo_m, 32'hFFFF_FFFD);

      // mthi / mtlo: single cycle, no start, read in same cycle sees old value.
      a = 32'd5; mthi = 1'b1; mfhi = 1'b1; #1;
      chk("mthi_start", 32'(start), 32'd0);
      chk("mthi_old_read", multdivout, hi_m);
      @(posedge clk); #1;
      mthi = 1'b0; mfhi = 1'b0; hi_m = 32'd5;
      chk("mthi_busy", 32'(busy), 32'd0);
      a = 32'd5; mtlo = 1'b1; mflo = 1'b1; #1;
      chk("mtlo_start", 32'(start), 32'd0);
      chk("mtlo_old_read", multdivout, lo_m);
      @(posedge clk); #1;
      mtlo = 1'b0; mflo = 1'b0; lo_m = 32'd5;
      check_regs("mt");

      op("mult_ff", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      chk("mult_ff_lo_const", lo_m, 32'd1);
      op("multu_ff", 4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      chk("multu_ff_hi_const", hi_m, 32'hFFFF_FFFE);
      op("divu_by0", 4'b0001, 32'd1234, 32'd0, 0);
      op("div_by0", 4'b0010, 32'h8000_0000, 32'd0, 2);
      op("div_ovf", 4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      chk("div_ovf_lo_const", lo_m, 32'h8000_0000);
      op("mult_inject", 4'b1000, 32'd1000, 32'hFFFF_FFF0, 1);
      op("prio_all", 4'b1111, 32'd12, 32'd12, 0);
      op("prio_div", 4'b0011, 32'hFFFF_FF00, 32'd7, 1);

      for (int i = 0; i < 30; i++) begin
         req = 4'b0001 << $urandom_range(0, 3);
         x   = $urandom;
         case ($urandom_range(0, 7))
            0:       y = 32'h0;
            1:       y = 32'($urandom_range(1, 20));
            2:       y = 32'hFFFF_FFFF;
            default: y = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) x = 32'($urandom_range(0, 100));
         op("rand", req, x, y, int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
